debug_unit_mips: RTL and testbench
==================================

Name: debug_unit_mips

Overview:
- Hardware replacement for the bench-level clock gating and latch dumping around the MIPS pipeline.
- Gates the pipeline through a clock-enable and accepts run / step / N-step commands.
- On halt, drains the pipeline for a parametrised number of cycles and counts enabled cycles.
- At each step end and at halt, captures a flat snapshot of all inter-stage latches and streams it out as NB_OUT-bit words over a valid/ready handshake.
- Sits between the external debug host (UART side) and the pipeline top.

Parameters:
- LEN, 32, width of cycle counter and step count.
- NB_SNAP, 453, width of concatenated latch snapshot (IF/ID 65 + ID/EX 204 + EX/MEM 112 + MEM/WB 72).
- NB_OUT, 8, width of each output word.
- HALT_DRAIN, 4, enabled cycles after halt detection before freezing.

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, reset, synchronous, active-low.
- i_cmd_valid, input, 1, command strobe.
- i_cmd, input, 2, command code: 00 NOP, 01 RUN, 10 STEP, 11 STEPN.
- i_step_count, input, LEN, cycle count for STEPN.
- o_cmd_ready, output, 1, high only in IDLE.
- i_halt, input, 1, halt flag from the fetch stage.
- i_snapshot, input, NB_SNAP, concatenated pipeline latches.
- o_clk_en, output, 1, pipeline clock enable.
- o_cycle_count, output, LEN, count of enabled cycles.
- o_halted, output, 1, high in HALTED.
- o_data, output, NB_OUT, snapshot word.
- o_data_valid, output, 1, word valid.
- o_data_last, output, 1, marks final word of a dump.
- i_data_ready, input, 1, consumer accepts word.

Behaviour:
- Reset: i_rst==0 at a rising edge forces state IDLE and clears everything. After reset: o_clk_en=0, o_cycle_count=0, o_halted=0, o_data=0, o_data_valid=0, o_data_last=0, o_cmd_ready=1. Reset applies from any state, including mid-dump and mid-drain; any partial dump is discarded.
- States: IDLE, RUN, STEP, DRAIN, DUMP, HALTED. o_clk_en is a Moore decode of the state: 1 in RUN, STEP and DRAIN, 0 otherwise.
- IDLE:
  - Command accepted when i_cmd_valid=1.
  - RUN -> RUN.
  - STEP -> STEP with remaining=1.
  - STEPN -> STEP with remaining=i_step_count. If i_step_count==0, stay in IDLE (no-op).
  - NOP stays in IDLE.
  - Commands presented in any non-IDLE state are ignored.
- Cycle counter: o_cycle_count increments by 1 on every edge where o_clk_en=1, including drain cycles. Wraps from 2^LEN-1 to 0.
- RUN: continues until i_halt=1 is sampled with o_clk_en=1, then -> DRAIN with drain counter=HALT_DRAIN. No dump is produced while running.
- STEP: remaining decrements each enabled cycle. When remaining reaches 0, go to DUMP with return target IDLE. A STEPN of N yields exactly N enabled cycles.
- Halt during STEP: the halt sample takes priority over step completion, including on the last step cycle -> DRAIN.
- DRAIN: exactly HALT_DRAIN further enabled cycles, then DUMP with return target HALTED. HALT_DRAIN=0 goes directly to DUMP. i_halt is ignored while in DRAIN.
- DUMP entry: i_snapshot is registered on the transition edge (the edge ending the last enabled cycle, so it reflects the latches after that cycle).
- DUMP streaming:
  - NW = ceil(NB_SNAP/NB_OUT) words, default 57.
  - Word k = bits [NB_SNAP-1-k*NB_OUT -: NB_OUT], sent MSB word first.
  - The final partial word is left-aligned, with zero-padded LSBs (default word 56: 5 data bits + 3 zero bits).
  - o_data_valid rises the cycle after DUMP entry.
  - A word transfers on an edge with o_data_valid && i_data_ready.
  - o_data and o_data_last are held stable while valid && !ready.
  - o_data_last=1 only on word NW-1.
  - After the last transfer, valid drops next cycle and state moves to the return target.
- HALTED: o_halted=1, o_clk_en=0, o_cmd_ready=0. Only reset exits this state.
- Snapshot capture happens once per dump; i_snapshot changes during DUMP have no effect.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles -> o_clk_en=0, o_cycle_count=0, o_data_valid=0, o_cmd_ready=1.
- STEPN: i_step_count=3, i_data_ready=1 -> o_clk_en high exactly 3 cycles; count=3; 57 words, o_data_last on the 57th; word 0 = i_snapshot[452:445]; word 56 = {i_snapshot[4:0],3'b000}; returns to IDLE with o_cmd_ready=1.
- Backpressure: during a dump, drive i_data_ready with a 1-0-0-1 pattern -> o_data stable while stalled; 57 words total, no duplicates or drops (scoreboard against the captured snapshot).
- RUN with halt: i_halt pulsed on the 10th enabled cycle -> 4 more enabled cycles; count=14; one dump; then o_halted=1; RUN/STEP commands afterwards ignored, count stays 14.
- Halt on the final cycle of STEPN 5 -> drain taken; count=9; end state HALTED.
- Edge cases:
  - STEPN 0 -> no enabled cycles, stays IDLE.
  - LEN=4 with RUN for 17 cycles -> count=1 (wrap).
  - i_rst=0 asserted at word 20 of a dump -> valid=0 and IDLE on the next edge.

Source files
------------

// File: rtl/debug_unit_mips.sv
// -----------------------------------------------------------------------------
// debug_unit_mips
//   Debug controller that sits between the external debug host (UART side) and
//   the MIPS pipeline top. It gates the pipeline through a clock enable, runs
//   RUN / STEP / STEPN commands, drains the pipeline after a halt, counts
//   enabled cycles and streams a snapshot of all inter-stage latches as a
//   sequence of NB_OUT-bit words over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst        : clock, synchronous active-low reset
//   i_cmd_valid, i_cmd  : command strobe and code (00 NOP, 01 RUN, 10 STEP,
//                         11 STEPN)
//   i_step_count        : cycle count for STEPN
//   o_cmd_ready         : high only while idle
//   i_halt              : halt flag from the fetch stage
//   i_snapshot          : concatenated IF/ID, ID/EX, EX/MEM, MEM/WB latches
//   o_clk_en            : pipeline clock enable
//   o_cycle_count       : number of enabled cycles (wraps)
//   o_halted            : program halted, only reset leaves this state
//   o_data, o_data_valid, o_data_last, i_data_ready : snapshot word stream
// -----------------------------------------------------------------------------
module debug_unit_mips #(
  parameter int LEN        = 32,
  parameter int NB_SNAP    = 453,
  parameter int NB_OUT     = 8,
  parameter int HALT_DRAIN = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  input  logic [LEN-1:0]     i_step_count,
  output logic               o_cmd_ready,
  input  logic               i_halt,
  input  logic [NB_SNAP-1:0] i_snapshot,
  output logic               o_clk_en,
  output logic [LEN-1:0]     o_cycle_count,
  output logic               o_halted,
  output logic [NB_OUT-1:0]  o_data,
  output logic               o_data_valid,
  output logic               o_data_last,
  input  logic               i_data_ready
);

  localparam int NW     = (NB_SNAP + NB_OUT - 1) / NB_OUT;  // words per dump
  localparam int NB_PAD = NW * NB_OUT;                      // padded snapshot
  localparam int IDX_W  = $clog2(NW + 1);
  localparam int DW     = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_STEPN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_DUMP,
    S_HALTED
  } state_t;

  state_t             state_q;
  logic [LEN-1:0]     cycle_q;
  logic [LEN-1:0]     remaining_q;
  logic [DW-1:0]      drain_q;
  logic [NB_PAD-1:0]  snap_q;
  logic [IDX_W-1:0]   word_q;
  logic               valid_q;
  logic               ret_halted_q;

  logic               clk_en;
  logic               xfer;
  logic               last_word;
  logic [NB_PAD-1:0]  snap_pad_d;
  logic               dump_start_d;
  logic               dump_to_halt_d;

  assign clk_en     = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
  assign xfer       = valid_q && i_data_ready;
  assign last_word  = (word_q == IDX_W'(NW - 1));
  // Left-align the snapshot so the final partial word carries zero LSBs.
  assign snap_pad_d = NB_PAD'(i_snapshot) << (NB_PAD - NB_SNAP);

  // Decide whether this edge ends the last enabled cycle before a dump.
  // NOTE: both outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    dump_start_d   = 1'b0;
    dump_to_halt_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (i_halt && HALT_DRAIN == 0) begin
          dump_start_d   = 1'b1;
          dump_to_halt_d = 1'b1;
        end
      end
      S_STEP: begin
        // A halt sample wins over step completion, even on the last step.
        if (i_halt) begin
          if (HALT_DRAIN == 0) begin
            dump_start_d   = 1'b1;
            dump_to_halt_d = 1'b1;
          end
        end else if (remaining_q == LEN'(1)) begin
          dump_start_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q <= DW'(1)) begin
          dump_start_d   = 1'b1;
          dump_to_halt_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      cycle_q      <= '0;
      remaining_q  <= '0;
      drain_q      <= '0;
      // NOTE: the wide snapshot register is reset too, because it drives
      // o_data directly and o_data must read zero after reset.
      snap_q       <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      ret_halted_q <= 1'b0;
    end else begin
      if (clk_en) begin
        cycle_q <= cycle_q + LEN'(1);
      end

      if (dump_start_d) begin
        state_q      <= S_DUMP;
        ret_halted_q <= dump_to_halt_d;
        snap_q       <= snap_pad_d;
        word_q       <= '0;
        valid_q      <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_cmd_valid) begin
              case (i_cmd)
                CMD_RUN: state_q <= S_RUN;
                CMD_STEP: begin
                  remaining_q <= LEN'(1);
                  state_q     <= S_STEP;
                end
                CMD_STEPN: begin
                  if (i_step_count != '0) begin
                    remaining_q <= i_step_count;
                    state_q     <= S_STEP;
                  end
                end
                default: ;
              endcase
            end
          end
          S_RUN: begin
            if (i_halt) begin
              drain_q <= DW'(HALT_DRAIN);
              state_q <= S_DRAIN;
            end
          end
          S_STEP: begin
            if (i_halt) begin
              drain_q <= DW'(HALT_DRAIN);
              state_q <= S_DRAIN;
            end else begin
              remaining_q <= remaining_q - LEN'(1);
            end
          end
          S_DRAIN: drain_q <= drain_q - DW'(1);
          S_DUMP: begin
            if (xfer) begin
              if (last_word) begin
                valid_q <= 1'b0;
                state_q <= ret_halted_q ? S_HALTED : S_IDLE;
              end else begin
                word_q <= word_q + IDX_W'(1);
                snap_q <= snap_q << NB_OUT;
              end
            end
          end
          default: ;  // S_HALTED: only reset leaves
        endcase
      end
    end
  end

  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_halted      = (state_q == S_HALTED);
  assign o_clk_en      = clk_en;
  assign o_cycle_count = cycle_q;
  assign o_data        = snap_q[NB_PAD-1 -: NB_OUT];
  assign o_data_valid  = valid_q;
  assign o_data_last   = valid_q && last_word;

endmodule

// File: tb/tb_debug_unit_mips.sv
// -----------------------------------------------------------------------------
// tb_debug_unit_mips
//   Randomized self-checking bench for debug_unit_mips. Expected dump words
//   are pushed into a scoreboard queue when a command is issued; a monitor
//   pops and compares whenever a word transfers. Cycle counts are predicted
//   from the command arithmetic (N steps, halt cycle + drain length).
// -----------------------------------------------------------------------------
module tb_debug_unit_mips;

  localparam int LEN        = 32;
  localparam int NB_SNAP    = 453;
  localparam int NB_OUT     = 8;
  localparam int HALT_DRAIN = 4;
  localparam int NW         = (NB_SNAP + NB_OUT - 1) / NB_OUT;
  localparam int NB_PAD     = NW * NB_OUT;
  localparam int LIMIT      = 4000;

  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_STEPN = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic               i_rst, i_cmd_valid, i_halt, i_data_ready;
  logic [1:0]         i_cmd;
  logic [LEN-1:0]     i_step_count;
  logic [NB_SNAP-1:0] i_snapshot;
  logic               o_cmd_ready, o_clk_en, o_halted, o_data_valid, o_data_last;
  logic [LEN-1:0]     o_cycle_count;
  logic [NB_OUT-1:0]  o_data;

  debug_unit_mips #(.LEN(LEN), .NB_SNAP(NB_SNAP), .NB_OUT(NB_OUT), .HALT_DRAIN(HALT_DRAIN)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_step_count(i_step_count), .o_cmd_ready(o_cmd_ready), .i_halt(i_halt),
    .i_snapshot(i_snapshot), .o_clk_en(o_clk_en), .o_cycle_count(o_cycle_count),
    .o_halted(o_halted), .o_data(o_data), .o_data_valid(o_data_valid),
    .o_data_last(o_data_last), .i_data_ready(i_data_ready)
  );

  // narrow-counter instance for the wrap check
  logic               s_rst, s_cmd_valid;
  logic [1:0]         s_cmd;
  logic [3:0]         s_step_count;
  logic [NB_SNAP-1:0] s_snapshot;
  logic               s_cmd_ready, s_clk_en, s_halted, s_data_valid, s_data_last;
  logic [3:0]         s_cycle_count;
  logic [NB_OUT-1:0]  s_data;

  debug_unit_mips #(.LEN(4), .NB_SNAP(NB_SNAP), .NB_OUT(NB_OUT), .HALT_DRAIN(HALT_DRAIN)) dut_w (
    .i_clk(clk), .i_rst(s_rst), .i_cmd_valid(s_cmd_valid), .i_cmd(s_cmd),
    .i_step_count(s_step_count), .o_cmd_ready(s_cmd_ready), .i_halt(1'b0),
    .i_snapshot(s_snapshot), .o_clk_en(s_clk_en), .o_cycle_count(s_cycle_count),
    .o_halted(s_halted), .o_data(s_data), .o_data_valid(s_data_valid),
    .o_data_last(s_data_last), .i_data_ready(1'b1)
  );

  typedef struct {
    logic [NB_OUT-1:0] data;
    logic              last;
  } word_t;

  word_t              sb[$];
  int                 vectors     = 0;
  int                 miscompares = 0;
  int                 xfer_cnt    = 0;
  int                 en_cnt      = 0;
  int                 ready_mode  = 0;
  int                 rphase      = 0;
  logic [NB_SNAP-1:0] snap_hold;
  logic               stall_pending = 1'b0;
  logic [NB_OUT-1:0]  stall_data;
  logic               stall_last;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NB_SNAP-1:0] rand_snap();
    logic [NB_SNAP-1:0] s = '0;
    for (int i = 0; i < (NB_SNAP + 31) / 32; i++) s = (s << 32) | NB_SNAP'($urandom);
    return s;
  endfunction

  // Reference: the dump is the snapshot left-aligned in NW words, MSB word first.
  task automatic push_dump(input logic [NB_SNAP-1:0] s);
    logic [NB_PAD-1:0] p;
    word_t w;
    p = {s, {(NB_PAD - NB_SNAP){1'b0}}};
    for (int k = 0; k < NW; k++) begin
      w.data = NB_OUT'(p >> ((NW - 1 - k) * NB_OUT));
      w.last = (k == NW - 1);
      sb.push_back(w);
    end
  endtask

  // Consumer ready pattern and snapshot source (scrambled while dumping).
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: i_data_ready = 1'b1;
      1: begin
        i_data_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
        rphase++;
      end
      default: i_data_ready = 1'($urandom);
    endcase
    i_snapshot = o_data_valid ? rand_snap() : snap_hold;
  end

  // Enabled-cycle observer.
  always @(negedge clk) begin
    if (i_rst && o_clk_en) en_cnt++;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    word_t w;
    if (i_rst && o_data_valid) begin
      if (stall_pending)
        check("stall_hold", 64'({o_data_last, o_data}), 64'({stall_last, stall_data}));
      if (i_data_ready) begin
        stall_pending = 1'b0;
        xfer_cnt++;
        if (sb.size() == 0) begin
          check("spurious_word", 64'(o_data), 64'hffff_ffff);
        end else begin
          w = sb.pop_front();
          check("dump_word", 64'(o_data), 64'(w.data));
          check("dump_last", 64'(o_data_last), 64'(w.last));
        end
      end else begin
        stall_pending = 1'b1;
        stall_data    = o_data;
        stall_last    = o_data_last;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic send_cmd(input logic [1:0] c, input logic [LEN-1:0] n);
    @(posedge clk);
    #1 i_cmd_valid = 1'b1;
    i_cmd        = c;
    i_step_count = n;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit to_halt, input string name);
    int i;
    for (i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_data_valid && (to_halt ? o_halted : o_cmd_ready)) break;
    end
    check(name, 64'(i < LIMIT), 64'(1));
  endtask

  // Raises halt during the n-th enabled cycle so it is sampled at its end.
  task automatic halt_on_cycle(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk);
      if (o_clk_en) seen++;
    end
    i_halt = 1'b1;
    check(name, 64'(seen), 64'(n));
    @(posedge clk);
    #1 i_halt = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 i_rst = 1'b0;
    i_cmd_valid = 1'b0;
    i_halt      = 1'b0;
    repeat (n) @(posedge clk);
    #1 i_rst = 1'b1;
    sb.delete();
  endtask

  initial begin
    int e0, total, n, x0, i;
    i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'b00; i_step_count = '0;
    i_halt = 1'b0; i_data_ready = 1'b1;
    snap_hold = rand_snap(); i_snapshot = snap_hold;
    s_rst = 1'b0; s_cmd_valid = 1'b0; s_cmd = 2'b00; s_step_count = '0; s_snapshot = '0;

    // Reset state
    do_reset(3);
    @(negedge clk);
    check("rst_clk_en", 64'(o_clk_en), 64'(0));
    check("rst_count", 64'(o_cycle_count), 64'(0));
    check("rst_valid", 64'(o_data_valid), 64'(0));
    check("rst_last", 64'(o_data_last), 64'(0));
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_halted", 64'(o_halted), 64'(0));
    check("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));

    // STEPN 3 with an always-ready consumer
    snap_hold = rand_snap(); push_dump(snap_hold); e0 = en_cnt;
    send_cmd(C_STEPN, 3);
    wait_done(1'b0, "stepn3_done");
    check("stepn3_en_cycles", 64'(en_cnt - e0), 64'(3));
    check("stepn3_count", 64'(o_cycle_count), 64'(3));
    check("stepn3_cmd_ready", 64'(o_cmd_ready), 64'(1));
    check("stepn3_clk_en", 64'(o_clk_en), 64'(0));
    total = 3;

    // Random STEPN lengths with random backpressure
    ready_mode = 2;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 6);
      snap_hold = rand_snap(); push_dump(snap_hold); e0 = en_cnt;
      send_cmd(C_STEPN, LEN'(n));
      wait_done(1'b0, "stepn_rand_done");
      total += n;
      check("stepn_rand_en_cycles", 64'(en_cnt - e0), 64'(n));
      check("stepn_rand_count", 64'(o_cycle_count), 64'(total));
    end

    // STEPN 0 is a no-op
    e0 = en_cnt;
    send_cmd(C_STEPN, 0);
    repeat (5) @(negedge clk);
    check("stepn0_en_cycles", 64'(en_cnt - e0), 64'(0));
    check("stepn0_cmd_ready", 64'(o_cmd_ready), 64'(1));
    check("stepn0_count", 64'(o_cycle_count), 64'(total));

    // Single STEP with 1-0-0-1 backpressure
    ready_mode = 1; rphase = 0;
    snap_hold = rand_snap(); push_dump(snap_hold);
    send_cmd(C_STEP, 0);
    wait_done(1'b0, "bp_done");
    total += 1;
    check("bp_count", 64'(o_cycle_count), 64'(total));

    // Reset in the middle of a dump
    ready_mode = 0;
    snap_hold = rand_snap(); push_dump(snap_hold);
    x0 = xfer_cnt;
    send_cmd(C_STEP, 0);
    for (i = 0; i < LIMIT; i++) begin
      @(posedge clk);
      if (xfer_cnt - x0 >= 20) break;
    end
    check("middump_reached", 64'(i < LIMIT), 64'(1));
    #1 i_rst = 1'b0;
    @(posedge clk);
    #1;
    check("middump_valid", 64'(o_data_valid), 64'(0));
    check("middump_idle", 64'(o_cmd_ready), 64'(1));
    check("middump_count", 64'(o_cycle_count), 64'(0));
    i_rst = 1'b1;
    sb.delete();

    // RUN, halt on the 10th enabled cycle
    snap_hold = rand_snap(); push_dump(snap_hold); e0 = en_cnt;
    send_cmd(C_RUN, 0);
    halt_on_cycle(10, "run_halt_cycle");
    wait_done(1'b1, "run_halt_done");
    check("run_halt_count", 64'(o_cycle_count), 64'(14));
    check("run_halt_en_cycles", 64'(en_cnt - e0), 64'(14));
    check("run_halted", 64'(o_halted), 64'(1));
    check("run_halted_cmd_ready", 64'(o_cmd_ready), 64'(0));
    send_cmd(C_RUN, 0);
    send_cmd(C_STEP, 0);
    repeat (10) @(negedge clk);
    check("halted_ignore_count", 64'(o_cycle_count), 64'(14));
    check("halted_ignore_clk_en", 64'(o_clk_en), 64'(0));
    check("halted_stays", 64'(o_halted), 64'(1));

    // Halt on the last cycle of STEPN 5
    do_reset(2);
    snap_hold = rand_snap(); push_dump(snap_hold);
    send_cmd(C_STEPN, 5);
    halt_on_cycle(5, "stepn5_halt_cycle");
    wait_done(1'b1, "stepn5_halt_done");
    check("stepn5_halt_count", 64'(o_cycle_count), 64'(9));
    check("stepn5_halted", 64'(o_halted), 64'(1));

    // Counter wrap with LEN=4: 17 enabled cycles leave 1
    @(posedge clk);
    #1 s_rst = 1'b1; s_cmd_valid = 1'b1; s_cmd = C_RUN;
    @(posedge clk);
    #1 s_cmd_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && n < 17; k++) begin
      @(negedge clk);
      if (s_clk_en) n++;
    end
    @(posedge clk);
    #1;
    check("wrap_count", 64'(s_cycle_count), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
